// File: rtl/bcd_cascade_counter_if.sv
// Control/status bundle between the tick/button logic and a BCD cascade counter.
// The counter takes the slave side; the driving logic (or a bench) takes the master side.
interface bcd_cascade_counter_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  carry_out;
    logic                  ovf;

    modport master (
        output en, up, clr, load, load_val,
        input  count, carry_out, ovf
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, carry_out, ovf
    );
endinterface

// File: rtl/bcd_cascade_counter.sv
// N-digit cascaded up/down counter with programmable per-digit modulus, load, clear and a
// sticky overflow flag. carry_out is combinational so further instances can chain off it.
module bcd_cascade_counter #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned MAX_DIGIT = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_cascade_counter_if.slave    bus
);
    localparam logic [3:0] MaxNib = 4'(MAX_DIGIT);

    logic [DIGITS-1:0][3:0] digit_q, digit_d;
    logic                   ovf_q, ovf_d;
    logic [DIGITS-1:0]      term;
    logic [DIGITS:0]        carry;
    logic [3:0]             nib;

    // carry[i] is the carry-in of digit i; carry[DIGITS] is the cascade output.
    always_comb begin
        term     = '0;
        carry    = '0;
        carry[0] = bus.en;
        for (int i = 0; i < DIGITS; i++) begin
            term[i]    = bus.up ? (digit_q[i] == MaxNib) : (digit_q[i] == 4'd0);
            carry[i+1] = carry[i] & term[i];
        end
    end

    always_comb begin
        digit_d = digit_q;
        ovf_d   = ovf_q;
        nib     = '0;
        if (bus.clr) begin
            digit_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib        = bus.load_val[4*i +: 4];
                digit_d[i] = (nib > MaxNib) ? 4'd0 : nib;
            end
        end else if (bus.en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry[i]) begin
                    if (bus.up) begin
                        digit_d[i] = (digit_q[i] == MaxNib) ? 4'd0 : digit_q[i] + 4'd1;
                    end else begin
                        digit_d[i] = (digit_q[i] == 4'd0) ? MaxNib : digit_q[i] - 4'd1;
                    end
                end
            end
            ovf_d = ovf_q | carry[DIGITS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            digit_q <= digit_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count     = digit_q;
    assign bus.carry_out = carry[DIGITS];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for two counter configurations (4 digits mod 10, 2 digits mod 6) against a model that
// treats the count as a single integer in base MAX_DIGIT+1.
module tb_bcd_cascade_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_cascade_counter_if #(.DIGITS(4)) if0 ();
    bcd_cascade_counter_if #(.DIGITS(2)) if1 ();

    bcd_cascade_counter #(.DIGITS(4), .MAX_DIGIT(9)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    bcd_cascade_counter #(.DIGITS(2), .MAX_DIGIT(5)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned ndig[2]  = '{4, 2};
    int unsigned maxd[2]  = '{9, 5};
    int unsigned mval[2];
    bit          movf[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned modulus(input int k);
        int unsigned m = 1;
        for (int i = 0; i < int'(ndig[k]); i++) m = m * (maxd[k] + 1);
        return m;
    endfunction

    // Integer value -> packed nibble display.
    function automatic logic [31:0] enc(input int k, input int unsigned v);
        logic [31:0] r = '0;
        for (int i = 0; i < int'(ndig[k]); i++) begin
            r[4*i +: 4] = 4'(v % (maxd[k] + 1));
            v = v / (maxd[k] + 1);
        end
        return r;
    endfunction

    function automatic int unsigned dec_load(input int k, input logic [31:0] lv);
        int unsigned v = 0;
        int unsigned n;
        for (int i = int'(ndig[k]) - 1; i >= 0; i--) begin
            n = 32'((lv >> (4*i)) & 32'hF);
            if (n > maxd[k]) n = 0;
            v = v * (maxd[k] + 1) + n;
        end
        return v;
    endfunction

    function automatic bit exp_carry(input int k, input bit e, input bit u);
        return e && (u ? (mval[k] == modulus(k) - 1) : (mval[k] == 0));
    endfunction

    // Called one time unit after a rising edge; drives, checks carry mid-cycle, then the result.
    task automatic step(input bit r, input bit e, input bit u, input bit c, input bit l,
                        input logic [15:0] lv0, input logic [7:0] lv1);
        bit          cy[2];
        logic [31:0] lv[2];
        rst = r;
        if0.en = e; if0.up = u; if0.clr = c; if0.load = l; if0.load_val = lv0;
        if1.en = e; if1.up = u; if1.clr = c; if1.load = l; if1.load_val = lv1;
        lv[0] = 32'(lv0);
        lv[1] = 32'(lv1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) cy[k] = exp_carry(k, e, u);
        check_eq("carry_out0", 32'(if0.carry_out), 32'(cy[0]));
        check_eq("carry_out1", 32'(if1.carry_out), 32'(cy[1]));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r || c) begin
                mval[k] = 0;
                movf[k] = 1'b0;
            end else if (l) begin
                mval[k] = dec_load(k, lv[k]);
            end else if (e) begin
                if (u) mval[k] = (mval[k] + 1) % modulus(k);
                else   mval[k] = (mval[k] + modulus(k) - 1) % modulus(k);
                if (cy[k]) movf[k] = 1'b1;
            end
        end
        #1;
        check_eq("count0", 32'(if0.count), enc(0, mval[0]));
        check_eq("ovf0",   32'(if0.ovf),   32'(movf[0]));
        check_eq("count1", 32'(if1.count), enc(1, mval[1]));
        check_eq("ovf1",   32'(if1.ovf),   32'(movf[1]));
    endtask

    initial begin
        if0.en = 0; if0.up = 1; if0.clr = 0; if0.load = 0; if0.load_val = '0;
        if1.en = 0; if1.up = 1; if1.clr = 0; if1.load = 0; if1.load_val = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        mval = '{0, 0};
        movf = '{0, 0};
        check_eq("reset_count", 32'(if0.count), 32'h0);
        check_eq("reset_ovf", 32'(if0.ovf), 32'h0);

        // Reset mid-count.
        step(0, 0, 1, 0, 1, 16'h0437, 8'h23);
        step(1, 1, 1, 0, 0, 16'h0000, 8'h00);
        check_eq("rst_mid", 32'(if0.count), 32'h0000);
        step(0, 1, 1, 0, 0, 16'h0000, 8'h00);
        check_eq("after_rst", 32'(if0.count), 32'h0001);

        // Ripple up; the small instance wraps fully from 0x55.
        step(0, 0, 1, 0, 1, 16'h0999, 8'h55);
        step(0, 1, 1, 0, 0, 16'h0000, 8'h00);
        check_eq("ripple", 32'(if0.count), 32'h1000);
        check_eq("small_wrap", 32'(if1.count), 32'h00);
        check_eq("small_ovf", 32'(if1.ovf), 32'h1);

        // Full overflow, then one more count.
        step(0, 0, 1, 0, 1, 16'h9999, 8'h55);
        step(0, 1, 1, 0, 0, 16'h0000, 8'h00);
        check_eq("ovf_wrap", 32'(if0.count), 32'h0000);
        check_eq("ovf_set", 32'(if0.ovf), 32'h1);
        step(0, 1, 1, 0, 0, 16'h0000, 8'h00);
        check_eq("ovf_sticky", 32'(if0.ovf), 32'h1);

        // Underflow after clear.
        step(0, 0, 1, 1, 0, 16'h0000, 8'h00);
        check_eq("clr_ovf", 32'(if0.ovf), 32'h0);
        step(0, 1, 0, 0, 0, 16'h0000, 8'h00);
        check_eq("underflow", 32'(if0.count), 32'h9999);
        step(0, 1, 0, 0, 0, 16'h0000, 8'h00);
        check_eq("under_next", 32'(if0.count), 32'h9998);

        // Priority and invalid nibble load.
        step(0, 0, 1, 0, 1, 16'h1234, 8'h12);
        step(0, 1, 1, 1, 1, 16'h5678, 8'h34);
        check_eq("clr_prio", 32'(if0.count), 32'h0000);
        step(0, 1, 1, 0, 1, 16'h12F4, 8'hF4);
        check_eq("bad_nibble", 32'(if0.count), 32'h1204);

        // Hold.
        for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, 1), 0, 0, 16'h0, 8'h0);
        check_eq("hold", 32'(if0.count), 32'h1204);

        // Random traffic, biased toward counting so carries and wraps occur.
        for (int i = 0; i < 400; i++) begin
            bit r, c, l, e, u;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 4);
            l = ($urandom_range(0, 99) < 8);
            e = ($urandom_range(0, 99) < 80);
            u = (i % 100 < 60) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            step(r, e, u, c, l, 16'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
